// File: rtl/oneshot_pkg.sv
// Shared types and default parameters for the single-pulse link transmitter.
package oneshot_pkg;

    localparam int DELAY_W_DEF = 8;
    localparam int LAT_W_DEF   = 5;
    localparam int EXP_LAT_DEF = 3;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        FIRE,
        ECHO,
        DONE
    } oneshot_state_e;

    typedef enum logic [1:0] {
        TMR_HOLD,
        TMR_LOAD,
        TMR_DEC,
        TMR_INC
    } tmr_op_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/oneshot_timer.sv
// Loadable counter: countdown for the pre-fire delay, count-up for echo latency.
module oneshot_timer
    import oneshot_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  tmr_op_e      op_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: cnt_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        case (op_i)
            TMR_LOAD: cnt_d = load_val_i;
            TMR_DEC:  if (cnt_q != '0) cnt_d = cnt_q - W'(1);
            TMR_INC:  if (cnt_q != '1) cnt_d = cnt_q + W'(1);
            default:  cnt_d = cnt_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/oneshot_pulse_tx.sv
// Single-pulse link transmitter: one delayed pulse per reset, echo latency
// measurement, timeout and sticky protocol-violation flag.
module oneshot_pulse_tx
    import oneshot_pkg::*;
#(
    parameter int DELAY_W = DELAY_W_DEF,
    parameter int LAT_W   = LAT_W_DEF,
    parameter int EXP_LAT = EXP_LAT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DELAY_W-1:0] delay,
    input  logic               echo,
    output logic               busy,
    output logic               pulse,
    output logic               done,
    output logic [LAT_W-1:0]   lat,
    output logic               lat_ok,
    output logic               timeout,
    output logic               proto_err
);

    localparam int CNT_W = max_int(DELAY_W, LAT_W);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);

    oneshot_state_e   state_q, state_d;
    logic             pulse_q, pulse_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             proto_err_q, proto_err_d;
    logic [LAT_W-1:0] lat_q, lat_d;

    tmr_op_e          tmr_op;
    logic [CNT_W-1:0] tmr_load_val;
    logic [CNT_W-1:0] cnt;

    oneshot_timer #(.W(CNT_W)) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .op_i       (tmr_op),
        .load_val_i (tmr_load_val),
        .cnt_o      (cnt)
    );

    always_comb begin
        state_d      = state_q;
        tmr_op       = TMR_HOLD;
        tmr_load_val = '0;
        done_d       = done_q;
        lat_d        = lat_q;
        timeout_d    = timeout_q;
        // Requests outside IDLE and echoes outside ECHO are ignored but remembered.
        proto_err_d  = proto_err_q
                     | (start && (state_q != IDLE))
                     | (echo  && (state_q != ECHO));

        case (state_q)
            IDLE: begin
                if (start) begin
                    tmr_op       = TMR_LOAD;
                    tmr_load_val = CNT_W'(delay);
                    state_d      = (delay == '0) ? FIRE : WAIT;
                end
            end
            WAIT: begin
                if (cnt <= CNT_ONE) state_d = FIRE;
                else                tmr_op  = TMR_DEC;
            end
            FIRE: begin
                tmr_op       = TMR_LOAD;
                tmr_load_val = CNT_ONE;
                state_d      = ECHO;
            end
            ECHO: begin
                // An echo landing on the timeout cycle still counts as a valid return.
                if (echo) begin
                    lat_d   = cnt[LAT_W-1:0];
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (cnt == CNT_TIMEOUT) begin
                    lat_d     = '0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmr_op = TMR_INC;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        pulse_d = (state_d == FIRE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pulse_q     <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            proto_err_q <= 1'b0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            proto_err_q <= proto_err_d;
            lat_q       <= lat_d;
        end
    end

    assign busy      = (state_q == WAIT) || (state_q == FIRE) || (state_q == ECHO);
    assign pulse     = pulse_q;
    assign done      = done_q;
    assign lat       = lat_q;
    assign timeout   = timeout_q;
    assign proto_err = proto_err_q;
    assign lat_ok    = done_q && (lat_q == LAT_W'(EXP_LAT)) && !timeout_q;

endmodule

// File: doc/oneshot_pulse_tx.md
# oneshot_pulse_tx

Transmit side of the single-pulse link: issues exactly one one-cycle `pulse` per reset, after a programmable delay from an accepted `start`. The pulse feeds a registered delay line whose tail returns as `echo`. The block measures pulse-to-echo latency and flags timeouts and protocol violations. Its output always honours the link contract: once `pulse` has been 1, it is 0 on every later cycle until reset.

## Interface
- `DELAY_W`, default 8: width of the `delay` request field.
- `LAT_W`, default 5: width of the latency counter and of `lat`.
- `EXP_LAT`, default 3: expected echo latency in cycles; matches a 3-stage line.
- `TIMEOUT`, default 16: cycles to wait for `echo` before giving up; must be less than 2^LAT_W.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  fire request; sampled only in IDLE.
- `delay`  in  DELAY_W  cycles between start acceptance and pulse; sampled with `start`.
- `echo`  in  1  tail of the delay line, carrying the returned pulse.
- `busy`  out  1  high in WAIT, FIRE and ECHO.
- `pulse`  out  1  registered one-shot output.
- `done`  out  1  sticky; set on leaving ECHO.
- `lat`  out  LAT_W  measured latency; valid when `done` is high.
- `lat_ok`  out  1  `done` && `lat` == EXP_LAT && !`timeout`.
- `timeout`  out  1  sticky; no echo arrived within TIMEOUT cycles.
- `proto_err`  out  1  sticky; any protocol violation.

## Operation
- States are IDLE, WAIT, FIRE, ECHO and DONE.
- **Reset.** Async `rst` forces state IDLE and clears the counter. All outputs go to 0 during reset, including `lat`.
- **IDLE.**
  - If `start` = 1: latch `delay` into the counter.
  - Go to FIRE if `delay` == 0; otherwise go to WAIT.
- **WAIT.** Decrement the counter each cycle. When it reaches 1, go to FIRE.
- **FIRE.**
  - `pulse` = 1 for exactly this cycle.
  - Load the counter with 1 and go to ECHO.
- **ECHO.**
  - If `echo` = 1: `lat` <= counter, set `done`, go to DONE.
  - Else if counter == TIMEOUT: set `timeout` and `done`, `lat` <= 0, go to DONE.
  - Otherwise increment the counter.
- **DONE.** Terminal state; only `rst` exits it. `pulse` stays 0 permanently.
- **`proto_err` is set (sticky) on any of:**
  - `start` = 1 in any state other than IDLE. The request is ignored, with no re-fire and no reload.
  - `echo` = 1 in IDLE, WAIT, FIRE or DONE.
- **Counter width.** The counter is max(DELAY_W, LAT_W) bits and never wraps. `delay` is zero-extended into it.
- **Echo vs. timeout.** If `echo` = 1 arrives on the same cycle as the counter reaching TIMEOUT, the echo wins: `lat` = TIMEOUT and `timeout` stays 0.

## Timing
- Let `start` be accepted at edge T with `delay` = D. `pulse` is high during cycle T+1+D.
  - D = 0 gives T+1; D = 1 gives T+2.
- `busy` rises at edge T and falls at the edge that enters DONE.
- With echo arriving L cycles after the pulse cycle: `lat` = L, and `done` rises at edge P+L, where P is the pulse cycle.
  - For a 3-stage registered line, L = 3.
- `done`, `lat`, `lat_ok` and `timeout` update on the same edge.
- **Reset mid-operation.** Asserting `rst` in WAIT, FIRE or ECHO drops `pulse` and `busy` asynchronously. A pulse in flight is never re-emitted from that run. After reset release the block is re-armable.

## Structure
- Package `oneshot_pkg` holds:
  - the state enum `oneshot_state_e` (IDLE, WAIT, FIRE, ECHO, DONE);
  - the default localparams for LAT_W, EXP_LAT and TIMEOUT.
- Sub-module `oneshot_timer`: a loadable counter with load, decrement and increment modes, width parameterised. It serves WAIT as a countdown and ECHO as a count-up.
- The top level holds the FSM and the sticky flags, about 150–250 lines total.
- The bench instantiates a 3-stage registered delay line (reset to 0) from `pulse` to `echo`. It binds the assertion: `pulse` == 1 implies `pulse` == 0 forever after, disabled during `rst`.

## Test plan
- Start with D = 0 at edge 10, 3-stage line → `pulse` high only in cycle 11; `done` at 14; `lat` = 3; `lat_ok` = 1; `timeout` = `proto_err` = 0.
- Start with D = 5 at edge 10 → `pulse` in cycle 16, `busy` 1 from edge 10 to edge 19, `lat` = 3.
- Start pulsed again at edges 12, 20 and 40 after a D = 2 run → no second pulse, `proto_err` = 1, `lat` unaffected.
- `echo` tied to 0, D = 0 → `timeout` = 1 and `done` = 1 at edge T+1+TIMEOUT; `lat` = 0; `lat_ok` = 0.
- 5-stage line in place of the 3-stage one → `lat` = 5, `lat_ok` = 0.
- Async `rst` in mid-WAIT (D = 8, asserted 3 cycles after start) → all outputs 0 immediately. A fresh start with D = 1 then fires once with `lat` = 3.
